// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers (shift-add multiply, restoring divide).
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU are reported as illegal ops.
module mdu_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             illegal_op
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam int SW = WIDTH + MUL_STEP;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
`ifdef MDU_DIV_EN
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
`endif

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef MDU_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_FIX  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic              qneg_q, qneg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;
  logic              ill_q, ill_d;
`ifdef MDU_DIV_EN
  logic              rneg_q, rneg_d;
  logic              divz_q, divz_d;
  logic              is_div_q, is_div_d;
`endif

  // Request decode and operand magnitudes
  logic             req;
  logic             is_mul, is_div, illegal;
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    req    = (state_q == S_IDLE) && start && !abort;
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_DIV_EN
    illegal = (op[2:1] == 2'b11);
`else
    illegal = (op[2:1] == 2'b11) || is_div;
`endif
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    a_neg = sgn && opr1[WIDTH-1];
    b_neg = sgn && opr2[WIDTH-1];
    a_mag = a_neg ? -opr1 : opr1;
    b_mag = b_neg ? -opr2 : opr2;
  end

  // Multiply step: add mag_q * (low MUL_STEP bits) to the upper half, then shift right
  logic [MUL_STEP-1:0] mul_bits;
  logic [SW-1:0]       mul_pp;
  logic [SW-1:0]       mul_sum;
  logic [W2-1:0]       mul_next;

  always_comb begin
    mul_bits = acc_q[MUL_STEP-1:0];
    mul_pp   = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mul_bits[i]) mul_pp = mul_pp + ({{MUL_STEP{1'b0}}, mag_q} << i);
    end
    mul_sum = {{MUL_STEP{1'b0}}, acc_q[W2-1:WIDTH]} + mul_pp;
  end

  generate
    if (MUL_STEP < WIDTH) begin : g_mul_shift
      assign mul_next = {mul_sum, acc_q[WIDTH-1:MUL_STEP]};
    end else begin : g_mul_full
      assign mul_next = mul_sum;
    end
  endgenerate

`ifdef MDU_DIV_EN
  // Restoring divide: acc = {remainder, dividend bits shifting into quotient}
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [W2-1:0]    div_next;

  always_comb begin
    div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    div_ge    = (div_shift >= {1'b0, mag_q});
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
  end
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req && !illegal && is_mul) state_d = S_MUL;
`ifdef MDU_DIV_EN
        else if (req && is_div)        state_d = S_DIV;
`endif
      end
      S_MUL: begin
        if (abort)              state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_FIX;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        if (abort)              state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_FIX;
      end
`endif
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath and architectural register next state
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    mag_d  = mag_q;
    qneg_d = qneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    ill_d  = 1'b0;
`ifdef MDU_DIV_EN
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    is_div_d = is_div_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (illegal) begin
            ill_d = 1'b1;
          end else if (op == OP_MTHI) begin
            hi_d   = opr1;
            done_d = 1'b1;
          end else if (op == OP_MTLO) begin
            lo_d   = opr1;
            done_d = 1'b1;
          end else if (is_mul) begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            mag_d  = a_mag;
            qneg_d = a_neg ^ b_neg;
            cnt_d  = MUL_LAST;
`ifdef MDU_DIV_EN
            is_div_d = 1'b0;
          end else begin
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            mag_d    = b_mag;
            qneg_d   = a_neg ^ b_neg;
            rneg_d   = a_neg;
            divz_d   = (opr2 == '0);
            cnt_d    = DIV_LAST;
            is_div_d = 1'b1;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - 1'b1;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - 1'b1;
      end
`endif
      S_FIX: begin
        if (!abort) begin
          done_d = 1'b1;
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            // Divide-by-zero keeps lo all ones; the remainder path already yields the raw dividend
            lo_d = divz_q ? '1 : (qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
            hi_d = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
          end else
`endif
          begin
            {hi_d, lo_d} = qneg_q ? -acc_q : acc_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      mag_q  <= '0;
      qneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      ill_q  <= 1'b0;
`ifdef MDU_DIV_EN
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      is_div_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      mag_q  <= mag_d;
      qneg_q <= qneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      ill_q  <= ill_d;
`ifdef MDU_DIV_EN
      rneg_q   <= rneg_d;
      divz_q   <= divz_d;
      is_div_q <= is_div_d;
`endif
    end
  end

  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: one instance with MUL_STEP=1 and one with MUL_STEP=4.
module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic [2:0]  op;
  logic [31:0] opr1, opr2;
  logic        abort;
  logic        busy_a, done_a, ill_a;
  logic [31:0] hi_a, lo_a;
  logic        busy_b, done_b, ill_b;
  logic [31:0] hi_b, lo_b;

  int n_pass  = 0;
  int n_total = 0;
  logic seen;

  mdu_iter #(.WIDTH(32), .MUL_STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_a), .op(op), .opr1(opr1), .opr2(opr2),
    .abort(abort), .busy(busy_a), .done(done_a), .hi(hi_a), .lo(lo_a),
    .illegal_op(ill_a)
  );

  mdu_iter #(.WIDTH(32), .MUL_STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start_b), .op(op), .opr1(opr1), .opr2(opr2),
    .abort(abort), .busy(busy_b), .done(done_b), .hi(hi_b), .lo(lo_b),
    .illegal_op(ill_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start_a = 0; start_b = 0; op = 3'd0; opr1 = '0; opr2 = '0; abort = 0;
    cyc(2);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset hi",   hi_a, 0);
    chk("reset lo",   lo_a, 0);
    chk("reset ill",  ill_a, 0);
    rst = 1'b0;
    cyc(1);

    // MULT -3 * 5 on MUL_STEP=1, with an ignored second start while busy
    op = 3'd0; opr1 = 32'hFFFF_FFFD; opr2 = 32'd5; start_a = 1;
    cyc(1);
    chk("mult busy T+1", busy_a, 1);
    op = 3'd5; opr1 = 32'hDEAD_BEEF; opr2 = 32'd0;
    cyc(1);
    start_a = 0;
    chk("start while busy ignored", lo_a, 0);
    cyc(31);
    chk("mult done low T+33", done_a, 0);
    chk("mult busy T+33", busy_a, 1);
    cyc(1);
    chk("mult done T+34", done_a, 1);
    chk("mult busy low T+34", busy_a, 0);
    chk("mult hi", hi_a, 32'hFFFF_FFFF);
    chk("mult lo", lo_a, 32'hFFFF_FFF1);
    cyc(1);
    chk("mult done one pulse", done_a, 0);

    // MULTU all-ones squared on MUL_STEP=4
    op = 3'd1; opr1 = 32'hFFFF_FFFF; opr2 = 32'hFFFF_FFFF; start_b = 1;
    cyc(1);
    start_b = 0;
    cyc(8);
    chk("multu4 done low T+9", done_b, 0);
    cyc(1);
    chk("multu4 done T+10", done_b, 1);
    chk("multu4 busy low T+10", busy_b, 0);
    chk("multu4 hi", hi_b, 32'hFFFF_FFFE);
    chk("multu4 lo", lo_b, 32'h0000_0001);

    // Signed MULT on MUL_STEP=4: both negative, then most-negative * 2
    op = 3'd0; opr1 = 32'hFFFF_FFFD; opr2 = 32'hFFFF_FFFC; start_b = 1;
    cyc(1);
    start_b = 0;
    cyc(9);
    chk("mult4 negneg done", done_b, 1);
    chk("mult4 negneg {hi,lo}", {hi_b, lo_b}, 64'h0000_0000_0000_000C);
    op = 3'd0; opr1 = 32'h8000_0000; opr2 = 32'd2; start_b = 1;
    cyc(1);
    start_b = 0;
    cyc(9);
    chk("mult4 minneg done", done_b, 1);
    chk("mult4 minneg {hi,lo}", {hi_b, lo_b}, 64'hFFFF_FFFF_0000_0000);

    // Abort at T+10: busy falls at T+11, no done, HI/LO keep prior values
    op = 3'd0; opr1 = 32'd7; opr2 = 32'd9; start_a = 1;
    cyc(1);
    start_a = 0;
    cyc(9);
    abort = 1;
    cyc(1);
    abort = 0;
    chk("abort busy low T+11", busy_a, 0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seen = seen | done_a | busy_a;
      cyc(1);
    end
    chk("abort no done/busy", seen, 0);
    chk("abort hi kept", hi_a, 32'hFFFF_FFFF);
    chk("abort lo kept", lo_a, 32'hFFFF_FFF1);

    // abort together with start in IDLE: start ignored
    op = 3'd5; opr1 = 32'h0000_0055; abort = 1; start_a = 1;
    cyc(1);
    start_a = 0; abort = 0;
    chk("abort+start no done", done_a, 0);
    chk("abort+start lo kept", lo_a, 32'hFFFF_FFF1);

    // MTLO / MTHI
    op = 3'd5; opr1 = 32'h1234_5678; start_a = 1;
    cyc(1);
    start_a = 0;
    chk("mtlo lo", lo_a, 32'h1234_5678);
    chk("mtlo done", done_a, 1);
    chk("mtlo busy", busy_a, 0);
    chk("mtlo hi kept", hi_a, 32'hFFFF_FFFF);
    op = 3'd4; opr1 = 32'hCAFE_BABE; start_a = 1;
    cyc(1);
    start_a = 0;
    chk("mthi hi", hi_a, 32'hCAFE_BABE);
    chk("mthi done", done_a, 1);

    // Illegal op 7
    op = 3'd7; opr1 = 32'h1111_1111; opr2 = 32'h2222_2222; start_a = 1;
    cyc(1);
    start_a = 0;
    chk("op7 ill", ill_a, 1);
    chk("op7 busy", busy_a, 0);
    chk("op7 done", done_a, 0);
    chk("op7 {hi,lo}", {hi_a, lo_a}, 64'hCAFE_BABE_1234_5678);
    cyc(1);
    chk("op7 ill one pulse", ill_a, 0);

`ifdef MDU_DIV_EN
    op = 3'd2; opr1 = 32'hFFFF_FFF9; opr2 = 32'd2; start_a = 1;
    cyc(1);
    start_a = 0;
    cyc(32);
    chk("div done low T+33", done_a, 0);
    cyc(1);
    chk("div done T+34", done_a, 1);
    chk("div lo", lo_a, 32'hFFFF_FFFD);
    chk("div hi", hi_a, 32'hFFFF_FFFF);
    op = 3'd3; opr1 = 32'd100; opr2 = 32'd0; start_a = 1;
    cyc(1);
    start_a = 0;
    cyc(33);
    chk("divu0 done T+34", done_a, 1);
    chk("divu0 lo", lo_a, 32'hFFFF_FFFF);
    chk("divu0 hi", hi_a, 32'h0000_0064);
    op = 3'd2; opr1 = 32'h8000_0000; opr2 = 32'hFFFF_FFFF; start_a = 1;
    cyc(1);
    start_a = 0;
    cyc(33);
    chk("div ovf lo", lo_a, 32'h8000_0000);
    chk("div ovf hi", hi_a, 32'h0000_0000);
    op = 3'd2; opr1 = 32'd1000; opr2 = 32'd3;
`else
    op = 3'd2; opr1 = 32'd1000; opr2 = 32'd3; start_a = 1;
    cyc(1);
    start_a = 0;
    chk("div disabled ill", ill_a, 1);
    chk("div disabled busy", busy_a, 0);
    chk("div disabled done", done_a, 0);
    chk("div disabled {hi,lo}", {hi_a, lo_a}, 64'hCAFE_BABE_1234_5678);
    op = 3'd0;
`endif

    // Asynchronous reset mid-operation at T+20
    start_a = 1;
    cyc(1);
    start_a = 0;
    chk("pre-rst busy", busy_a, 1);
    cyc(19);
    rst = 1'b1;
    #1;
    chk("async rst busy", busy_a, 0);
    chk("async rst hi", hi_a, 0);
    chk("async rst lo", lo_a, 0);
    chk("async rst hi s4", hi_b, 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
